// File: rtl/softmax_row_sequencer_if.sv
// Stream handshakes around the softmax row sequencer: logits in, x - max out.
interface softmax_row_sequencer_if;
    localparam int unsigned DATA_W = 16;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    // Sequencer side
    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    // Producer / consumer side
    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/softmax_row_sequencer.sv
// Loads one row of Q8.8 logits into the line buffer while tracking the row
// maximum, then reads it back and streams saturated x - max downstream.
module softmax_row_sequencer #(
    parameter int unsigned C_MAX  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W:0]         len,
    softmax_row_sequencer_if.master strm,
    output logic                    lb_we,
    output logic [ADDR_W-1:0]       lb_waddr,
    output logic [15:0]             lb_wdata,
    output logic [ADDR_W-1:0]       lb_raddr,
    input  logic [15:0]             lb_rdata,
    output logic [15:0]             row_max,
    output logic                    busy,
    output logic                    done
);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

    state_t                       state, state_next;
    logic [CNT_W-1:0]             row_len, row_len_next;
    logic [CNT_W-1:0]             wcnt, wcnt_next;
    logic [CNT_W-1:0]             rcnt, rcnt_next;
    logic [CNT_W-1:0]             len_clamped;
    logic [DATA_W-1:0]            max_next;
    logic                         in_ready;
    logic                         done_next;
    logic                         inflight, inflight_last;
    logic                         issue, issue_last;
    logic                         in_hs, pop;
    logic [2:0]                   occ_eff;
    logic [1:0]                   q_vld, q_vld_next;
    logic [1:0]                   q_last, q_last_next;
    logic [1:0][DATA_W-1:0]       q_data, q_data_next;
    logic [DATA_W:0]              diff;
    logic [DATA_W-1:0]            push_data;

    assign in_hs       = strm.in_valid & in_ready;
    assign pop         = q_vld[0] & strm.out_ready;
    assign len_clamped = (len > CNT_W'(C_MAX)) ? CNT_W'(C_MAX) : len;
    // Slots that will be taken after this cycle's pop; keeps a read going while the head drains.
    assign occ_eff     = 3'(q_vld[0]) + 3'(q_vld[1]) + 3'(inflight) - 3'(pop);
    // Both operands sign-extended to 17 bits, so the wrapped difference is exact.
    assign diff        = {lb_rdata[DATA_W-1], lb_rdata} - {row_max[DATA_W-1], row_max};

    // Saturate the difference into 16 bits and clamp it to be non-positive.
    always_comb begin
        push_data = diff[DATA_W-1:0];
        if (diff[DATA_W] && !diff[DATA_W-1]) begin
            push_data = {1'b1, {(DATA_W-1){1'b0}}};
        end else if (!diff[DATA_W]) begin
            push_data = '0;
        end
    end

    // Next-state, counters, running max, read issue and output queue update.
    always_comb begin
        state_next   = state;
        row_len_next = row_len;
        wcnt_next    = wcnt;
        rcnt_next    = rcnt;
        max_next     = row_max;
        done_next    = 1'b0;
        issue        = 1'b0;
        issue_last   = 1'b0;
        q_vld_next   = q_vld;
        q_last_next  = q_last;
        q_data_next  = q_data;

        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_next = 1'b1;
                        max_next  = '0;
                    end else begin
                        row_len_next = len_clamped;
                        wcnt_next    = '0;
                        rcnt_next    = '0;
                        state_next   = LOAD;
                    end
                end
            end
            LOAD: begin
                if (in_hs) begin
                    wcnt_next = wcnt + CNT_W'(1);
                    if (wcnt == '0 || $signed(strm.in_data) > $signed(row_max)) begin
                        max_next = strm.in_data;
                    end
                    if (wcnt == row_len - CNT_W'(1)) begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (rcnt < row_len && occ_eff < 3'd2) begin
                    issue      = 1'b1;
                    issue_last = (rcnt == row_len - CNT_W'(1));
                    rcnt_next  = rcnt + CNT_W'(1);
                end
                if (pop && q_last[0]) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (pop) begin
            q_data_next[0] = q_data[1];
            q_last_next[0] = q_last[1];
            q_vld_next[0]  = q_vld[1];
            q_vld_next[1]  = 1'b0;
            q_last_next[1] = 1'b0;
        end
        if (inflight) begin
            if (!q_vld_next[0]) begin
                q_vld_next[0]  = 1'b1;
                q_data_next[0] = push_data;
                q_last_next[0] = inflight_last;
            end else begin
                q_vld_next[1]  = 1'b1;
                q_data_next[1] = push_data;
                q_last_next[1] = inflight_last;
            end
        end
    end

    // State, counters, queue and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            row_len       <= '0;
            wcnt          <= '0;
            rcnt          <= '0;
            row_max       <= '0;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            q_vld         <= '0;
            q_last        <= '0;
            q_data        <= '0;
        end else begin
            state         <= state_next;
            row_len       <= row_len_next;
            wcnt          <= wcnt_next;
            rcnt          <= rcnt_next;
            row_max       <= max_next;
            in_ready      <= (state_next == LOAD);
            busy          <= (state_next != IDLE);
            done          <= done_next;
            inflight      <= issue;
            inflight_last <= issue_last;
            q_vld         <= q_vld_next;
            q_last        <= q_last_next;
            q_data        <= q_data_next;
        end
    end

    assign strm.in_ready  = in_ready;
    assign strm.out_valid = q_vld[0];
    assign strm.out_data  = q_data[0];
    assign strm.out_last  = q_last[0];
    assign lb_we          = in_hs;
    assign lb_waddr       = wcnt[ADDR_W-1:0];
    assign lb_wdata       = in_hs ? strm.in_data : '0;
    assign lb_raddr       = rcnt[ADDR_W-1:0];
endmodule
